aes_host_if: RTL and testbench

//  Parametrised narrow-bus host front end for AES_core: loads key/block over an IN_W-bit write port, issues init/next, returns
//  the 128-bit result over an OUT_W-bit read port. Replaces the fixed 16-in/8-out pin interface with explicit wr_en/rd_en strobes,

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_word_bank.sv | 47 ++++
 rtl/aes_host_if.sv | 198 +++++++++++++++++++
 tb/tb_aes_host_if.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : aes_pkg                                                         |
// | Purpose : Shared definitions for the AES host front end: register map,    |
// |           CONFIG/START/STATUS bit positions, FSM state type and a width   |
// |           legality helper.                                                |
// | Ports   : none                                                            |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package aes_pkg;

  // Register map
  localparam logic [3:0] c_addr_config  = 4'h1;
  localparam logic [3:0] c_addr_key     = 4'h2;
  localparam logic [3:0] c_addr_block   = 4'h3;
  localparam logic [3:0] c_addr_status  = 4'h4;
  localparam logic [3:0] c_addr_result  = 4'h5;
  localparam logic [3:0] c_addr_ptr_clr = 4'hE;
  localparam logic [3:0] c_addr_start   = 4'hF;

  // CONFIG bits
  localparam int c_cfg_encdec = 0;
  localparam int c_cfg_keylen = 1;

  // START bits
  localparam int c_start_init = 0;
  localparam int c_start_next = 1;

  // STATUS bits
  localparam int c_stat_ready     = 0;
  localparam int c_stat_busy      = 1;
  localparam int c_stat_res_avail = 2;
  localparam int c_stat_err       = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INIT_WAIT = 2'd1,
    ST_NEXT_WAIT = 2'd2
  } state_t;

  // Bus widths must divide both 128 and 256 and hold the 4-bit STATUS word.
  function automatic logic width_ok(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_word_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : aes_word_bank                                                   |
// | Purpose : N x W register file filled one word per write through a        |
// |           wrapping pointer; contents presented flat, word 0 in the MSBs.  |
// | Ports   : clk, rst_n (async, active-low)                                  |
// |           wr_en   - write data_in at pointer, advance pointer             |
// |           clr     - pointer back to word 0 (contents kept)                |
// |           data_in - W-bit write word                                      |
// |           words   - N*W-bit flattened contents                            |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module aes_word_bank #(
  parameter int W = 16,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic           clr,
  input  logic [W-1:0]   data_in,
  output logic [N*W-1:0] words
);

  localparam int c_pw = (N > 1) ? $clog2(N) : 1;

  logic [c_pw-1:0] r_ptr;
  logic [W-1:0]    r_mem [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (wr_en) begin
      r_mem[r_ptr] <= data_in;
      r_ptr        <= (r_ptr == c_pw'(N - 1)) ? '0 : r_ptr + c_pw'(1);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_flat
    assign words[(N - gi) * W - 1 -: W] = r_mem[gi];
  end

endmodule
`default_nettype wire

// File: rtl/aes_host_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : aes_host_if                                                     |
// | Purpose : Narrow-bus host front end for AES_core. Loads key/block over an |
// |           IN_W write port, issues init/next, returns the 128-bit result   |
// |           over an OUT_W read port, with busy-lock and sticky error flag.  |
// | Ports   : clk, rst_n (async, active-low)                                  |
// |           addr/wr_en/rd_en/data_in - host register access                 |
// |           data_out                  - registered read data                |
// |           core_encdec/keylen/init/next/key/block - to AES_core            |
// |           core_ready/result/valid   - from AES_core                       |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module aes_host_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [IN_W-1:0]  data_in,
  output logic [OUT_W-1:0] data_out,
  output logic             core_encdec,
  output logic             core_keylen,
  output logic             core_init,
  output logic             core_next,
  output logic [255:0]     core_key,
  output logic [127:0]     core_block,
  input  logic             core_ready,
  input  logic [127:0]     core_result,
  input  logic             core_valid
);

  import aes_pkg::*;

  localparam int c_key_words = 256 / IN_W;
  localparam int c_blk_words = 128 / IN_W;
  localparam int c_res_words = 128 / OUT_W;
  localparam int c_res_pw    = $clog2(c_res_words);

  if (!(width_ok(IN_W) && width_ok(OUT_W))) begin : g_bad_width
    $error("aes_host_if: IN_W and OUT_W must each be 8, 16 or 32");
  end

  state_t              r_state;
  logic                r_encdec;
  logic                r_keylen;
  logic                r_init;
  logic                r_next;
  logic [127:0]        r_res;
  logic                r_res_avail;
  logic [c_res_pw-1:0] r_res_ptr;
  logic                r_err;
  logic [OUT_W-1:0]    r_data_out;

  logic                w_busy;
  logic                w_rd;
  logic                w_key_wr;
  logic                w_blk_wr;
  logic                w_ptr_clr;
  logic                w_wr_locked;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_err_set;
  logic                w_rd_bad;
  logic [OUT_W-1:0]    w_rd_data;
  logic [OUT_W-1:0]    w_res_words [c_res_words];

  assign w_busy    = (r_state != ST_IDLE);
  // A simultaneous write wins; the read is dropped and flagged.
  assign w_rd      = rd_en & ~wr_en;
  assign w_key_wr  = wr_en & ~w_busy & (addr == c_addr_key);
  assign w_blk_wr  = wr_en & ~w_busy & (addr == c_addr_block);
  assign w_ptr_clr = wr_en & (addr == c_addr_ptr_clr);

  assign w_wr_locked = wr_en & ((addr == c_addr_config) | (addr == c_addr_key) |
                                (addr == c_addr_block)  | (addr == c_addr_start));
  assign w_start_ok  = wr_en & ~w_busy & (addr == c_addr_start) & core_ready;
  assign w_start_bad = wr_en & ~w_busy & (addr == c_addr_start) &
                       (~core_ready | (data_in[c_start_init] & data_in[c_start_next]));
  assign w_err_set   = (wr_en & rd_en) | (w_rd & w_rd_bad) | (w_busy & w_wr_locked) | w_start_bad;

  aes_word_bank #(.W(IN_W), .N(c_key_words)) u_key_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_key_wr),
    .clr     (w_ptr_clr),
    .data_in (data_in),
    .words   (core_key)
  );

  aes_word_bank #(.W(IN_W), .N(c_blk_words)) u_blk_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_blk_wr),
    .clr     (w_ptr_clr),
    .data_in (data_in),
    .words   (core_block)
  );

  // Result word 0 is the MSB slice.
  for (genvar gi = 0; gi < c_res_words; gi++) begin : g_res_word
    assign w_res_words[gi] = r_res[127 - gi * OUT_W -: OUT_W];
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_bad  = 1'b0;
    case (addr)
      c_addr_config: begin
        w_rd_data[c_cfg_keylen] = r_keylen;
        w_rd_data[c_cfg_encdec] = r_encdec;
      end
      c_addr_status: begin
        w_rd_data[c_stat_err]       = r_err;
        w_rd_data[c_stat_res_avail] = r_res_avail;
        w_rd_data[c_stat_busy]      = w_busy;
        w_rd_data[c_stat_ready]     = core_ready;
      end
      c_addr_result: w_rd_data = w_res_words[r_res_ptr];
      c_addr_key, c_addr_block, c_addr_ptr_clr, c_addr_start: w_rd_bad = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_encdec    <= 1'b0;
      r_keylen    <= 1'b0;
      r_init      <= 1'b0;
      r_next      <= 1'b0;
      r_res       <= '0;
      r_res_avail <= 1'b0;
      r_res_ptr   <= '0;
      r_err       <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_init <= 1'b0;
      r_next <= 1'b0;

      if (wr_en && !w_busy && addr == c_addr_config) begin
        r_keylen <= data_in[c_cfg_keylen];
        r_encdec <= data_in[c_cfg_encdec];
      end

      if (w_rd) begin
        r_data_out <= w_rd_data;
        if (addr == c_addr_result)
          r_res_ptr <= (r_res_ptr == c_res_pw'(c_res_words - 1)) ? '0 : r_res_ptr + c_res_pw'(1);
      end
      if (w_ptr_clr) r_res_ptr <= '0;

      // STATUS read reports the flag, then clears it; a new error this cycle wins.
      if (w_rd && addr == c_addr_status) r_err <= 1'b0;
      if (w_err_set) r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            if (data_in[c_start_init]) begin
              r_init  <= 1'b1;
              r_state <= ST_INIT_WAIT;
            end else if (data_in[c_start_next]) begin
              r_next      <= 1'b1;
              r_res_avail <= 1'b0;
              r_state     <= ST_NEXT_WAIT;
            end
          end
        end
        // The core has not yet seen the pulse while it is high, so its
        // ready/valid still describe the previous operation.
        ST_INIT_WAIT: begin
          if (!r_init && core_ready) r_state <= ST_IDLE;
        end
        ST_NEXT_WAIT: begin
          if (!r_next && core_valid) begin
            r_res       <= core_result;
            r_res_avail <= 1'b1;
            r_res_ptr   <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign core_encdec = r_encdec;
  assign core_keylen = r_keylen;
  assign core_init   = r_init;
  assign core_next   = r_next;

endmodule
`default_nettype wire

// File: tb/tb_aes_host_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_aes_host_if                                                  |
// | Purpose : Self-checking bench for aes_host_if (IN_W=16, OUT_W=8) with a   |
// |           behavioural AES core stub and a register-level reference model. |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_aes_host_if;

  localparam logic [3:0] A_CONFIG = 4'h1, A_KEY = 4'h2, A_BLOCK = 4'h3, A_STATUS = 4'h4,
                         A_RESULT = 4'h5, A_PTRCLR = 4'hE, A_START = 4'hF;
  localparam logic [127:0] FIXED_RES = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   addr = 4'h0;
  logic         wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0]  data_in = 16'h0;
  logic [7:0]   data_out;
  logic         core_encdec, core_keylen, core_init, core_next;
  logic [255:0] core_key;
  logic [127:0] core_block;
  logic         core_ready, core_valid;
  logic [127:0] core_result;

  int checks = 0;
  int failures = 0;

  logic [3:0] valid_addrs [7] = '{A_CONFIG, A_KEY, A_BLOCK, A_STATUS, A_RESULT, A_PTRCLR, A_START};
  logic [3:0] wo_addrs    [4] = '{A_KEY, A_BLOCK, A_PTRCLR, A_START};

  always #5 clk = ~clk;

  aes_host_if #(.IN_W(16), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .core_encdec(core_encdec),
    .core_keylen(core_keylen), .core_init(core_init), .core_next(core_next),
    .core_key(core_key), .core_block(core_block), .core_ready(core_ready),
    .core_result(core_result), .core_valid(core_valid)
  );

  // ---------------- AES core stub: fixed-ish latency after each pulse ------
  logic c_ready, c_valid, tb_hold = 1'b0, use_fixed = 1'b1;
  int   c_cnt, c_op;
  assign core_ready = c_ready & ~tb_hold;
  assign core_valid = c_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_ready <= 1'b1; c_valid <= 1'b0; c_cnt <= 0; c_op <= 0; core_result <= '0;
    end else if (core_init) begin
      c_ready <= 1'b0; c_cnt <= $urandom_range(2, 6); c_op <= 1;
    end else if (core_next) begin
      c_ready <= 1'b0; c_valid <= 1'b0; c_cnt <= $urandom_range(2, 6); c_op <= 2;
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) begin
        c_ready <= 1'b1;
        if (c_op == 2) begin
          c_valid     <= 1'b1;
          core_result <= use_fixed ? FIXED_RES : {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // ---------------- Reference model (register-level behaviour) ------------
  logic [15:0]  m_key [16];
  logic [15:0]  m_blk [8];
  int           m_kptr, m_bptr, m_rptr, m_kind;   // m_kind: 0 none, 1 init, 2 next
  logic [127:0] m_res;
  logic         m_avail, m_err, m_encdec, m_keylen, m_init, m_next;
  logic [7:0]   m_dout;

  function automatic logic [255:0] exp_key();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[255 - 16 * i -: 16] = m_key[i];
    return v;
  endfunction

  function automatic logic [127:0] exp_blk();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[127 - 16 * i -: 16] = m_blk[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic         busy_now, errset, p_init, p_next;
    int           old_kind;
    logic [127:0] tmp;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_key[i] = '0;
      for (int i = 0; i < 8; i++)  m_blk[i] = '0;
      m_kptr = 0; m_bptr = 0; m_rptr = 0; m_kind = 0; m_res = '0;
      m_avail = 0; m_err = 0; m_encdec = 0; m_keylen = 0; m_init = 0; m_next = 0; m_dout = '0;
    end else begin
      old_kind = m_kind; busy_now = (m_kind != 0);
      p_init = m_init; p_next = m_next;
      m_init = 0; m_next = 0;
      errset = wr_en && rd_en;
      if (rd_en && !wr_en) begin
        case (addr)
          A_CONFIG: m_dout = {6'b0, m_keylen, m_encdec};
          A_STATUS: begin m_dout = {4'b0, m_err, m_avail, busy_now, core_ready}; m_err = 0; end
          A_RESULT: begin
            tmp = m_res >> (8 * (15 - m_rptr)); m_dout = tmp[7:0];
            m_rptr = (m_rptr + 1) % 16;
          end
          A_KEY, A_BLOCK, A_PTRCLR, A_START: begin m_dout = 8'h00; errset = 1; end
          default: m_dout = 8'h00;
        endcase
      end
      if (wr_en) begin
        case (addr)
          A_CONFIG: if (busy_now) errset = 1; else begin m_keylen = data_in[1]; m_encdec = data_in[0]; end
          A_KEY:    if (busy_now) errset = 1; else begin m_key[m_kptr] = data_in; m_kptr = (m_kptr + 1) % 16; end
          A_BLOCK:  if (busy_now) errset = 1; else begin m_blk[m_bptr] = data_in; m_bptr = (m_bptr + 1) % 8; end
          A_PTRCLR: begin m_kptr = 0; m_bptr = 0; m_rptr = 0; end
          A_START: begin
            if (busy_now || !core_ready) errset = 1;
            else if (data_in[0]) begin m_init = 1; m_kind = 1; if (data_in[1]) errset = 1; end
            else if (data_in[1]) begin m_next = 1; m_avail = 0; m_kind = 2; end
          end
          default: ;
        endcase
      end
      if (old_kind == 1 && !p_init && core_ready) m_kind = 0;
      if (old_kind == 2 && !p_next && core_valid) begin
        m_res = core_result; m_avail = 1; m_rptr = 0; m_kind = 0;
      end
      if (errset) m_err = 1;
    end
  end

  // ---------------- Checking ----------------------------------------------
  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_core_init",   core_init,   m_init);
    check("model_core_next",   core_next,   m_next);
    check("model_data_out",    data_out,    m_dout);
    check("model_core_key",    core_key,    exp_key());
    check("model_core_block",  core_block,  exp_blk());
    check("model_core_encdec", core_encdec, m_encdec);
    check("model_core_keylen", core_keylen, m_keylen);
  end

  task automatic step(input logic w, input logic r, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 16'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 8'h00);
    check("reset_core_key", core_key, 256'h0);
    check("reset_core_init", core_init, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, A_KEY, 16'(i));
    check("lit_key_load", core_key,
          256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, A_BLOCK, 16'ha000 + 16'(i));
    check("lit_block_load", core_block, 128'ha000_a001_a002_a003_a004_a005_a006_a007);
    step(1'b1, 1'b0, A_KEY, 16'h1111);
    check("lit_key_ptr_wrap", core_key[255:224], 32'h1111_0002);
    step(1'b1, 1'b0, A_BLOCK, 16'hb000);
    check("lit_blk_ptr_wrap", core_block[127:96], 32'hb000_a001);

    step(1'b1, 1'b0, A_START, 16'h0001);
    check("lit_init_pulse_hi", core_init, 1'b1);
    idle(1);
    check("lit_init_pulse_lo", core_init, 1'b0);
    step(1'b0, 1'b1, A_STATUS, 16'h0);
    check("lit_status_busy", data_out, 8'h02);
    idle(12);
    step(1'b0, 1'b1, A_STATUS, 16'h0);
    check("lit_status_idle", data_out, 8'h01);

    step(1'b1, 1'b0, A_START, 16'h0002);
    check("lit_next_pulse_hi", core_next, 1'b1);
    idle(1);
    check("lit_next_pulse_lo", core_next, 1'b0);
    idle(12);
    step(1'b0, 1'b1, A_STATUS, 16'h0);
    check("lit_status_avail", data_out, 8'h05);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, A_RESULT, 16'h0);
      check("lit_result_word", data_out, 8'(8'h11 * i));
    end
    step(1'b0, 1'b1, A_RESULT, 16'h0);
    check("lit_result_wrap", data_out, 8'h00);

    step(1'b1, 1'b0, A_START, 16'h0001);
    step(1'b1, 1'b0, A_KEY, 16'hdead);
    check("lit_key_locked", core_key,
          256'h1111_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010);
    idle(12);
    step(1'b0, 1'b1, A_STATUS, 16'h0);
    check("lit_err_set", data_out, 8'h0d);
    step(1'b0, 1'b1, A_STATUS, 16'h0);
    check("lit_err_cleared", data_out, 8'h05);

    step(1'b1, 1'b0, A_PTRCLR, 16'h0);
    step(1'b1, 1'b0, A_KEY, 16'h0101);
    step(1'b1, 1'b0, A_KEY, 16'h0202);
    step(1'b1, 1'b0, A_KEY, 16'h0303);
    step(1'b1, 1'b0, A_PTRCLR, 16'hffff);
    step(1'b1, 1'b0, A_KEY, 16'hbeef);
    check("lit_ptr_clr", core_key[255:224], 32'hbeef_0202);

    step(1'b0, 1'b1, A_STATUS, 16'h0);
    check("lit_status_pre_rst", data_out, 8'h05);
    step(1'b1, 1'b0, A_START, 16'h0002);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    check("lit_rst_data_out", data_out, 8'h00);
    check("lit_rst_core_next", core_next, 1'b0);
    check("lit_rst_core_key", core_key, 256'h0);
    check("lit_rst_core_block", core_block, 128'h0);
    idle(1);
    @(negedge clk); rst_n = 1'b1;
    step(1'b0, 1'b1, A_STATUS, 16'h0);
    check("lit_status_after_rst", data_out, 8'h01);
    step(1'b1, 1'b0, A_KEY, 16'h7777);
    check("lit_key_after_rst", core_key, {16'h7777, 240'h0});
    step(1'b1, 1'b0, A_START, 16'h0001);
    check("lit_init_after_rst", core_init, 1'b1);
    idle(12);

    use_fixed = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      int r; logic w, rd; logic [3:0] a; logic [15:0] d;
      r = $urandom_range(0, 99); w = 1'b0; rd = 1'b0; a = 4'h0; d = 16'($urandom);
      tb_hold = ($urandom_range(0, 7) == 0);
      if      (r < 20) begin w = 1'b1; a = A_KEY; end
      else if (r < 30) begin w = 1'b1; a = A_BLOCK; end
      else if (r < 36) begin w = 1'b1; a = A_CONFIG; end
      else if (r < 52) begin rd = 1'b1; a = A_RESULT; end
      else if (r < 60) begin rd = 1'b1; a = A_STATUS; end
      else if (r < 64) begin rd = 1'b1; a = A_CONFIG; end
      else if (r < 74) begin w = 1'b1; a = A_START; d = 16'($urandom_range(0, 3)); end
      else if (r < 77) begin w = 1'b1; a = A_PTRCLR; end
      else if (r < 80) begin w = 1'b1; rd = 1'b1; a = valid_addrs[$urandom_range(0, 6)]; end
      else if (r < 83) begin rd = 1'b1; a = wo_addrs[$urandom_range(0, 3)]; end
      step(w, rd, a, d);
    end
    tb_hold = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
